// File: rtl/abs_diff_sched.sv
// ----------------------------------------------------------------------------
// abs_diff_sched
//   Two-requester scheduler and controller for a shared |A-B| datapath.
//   A round-robin arbiter picks one requester while idle and captures that
//   requester's unsigned operands. The FSM then sequences:
//     subtract -> (negate, only when the subtraction borrowed) -> done.
//   It returns the magnitude, a sign flag and the id of the served requester.
//
// Ports
//   clk_i      in   1      clock, rising edge
//   rst_b_i    in   1      asynchronous reset, active-low
//   req0_i     in   1      requester 0 request, held until gnt0_o
//   a0_i/b0_i  in   WIDTH  requester 0 operands A/B (unsigned)
//   req1_i     in   1      requester 1 request, held until gnt1_o
//   a1_i/b1_i  in   WIDTH  requester 1 operands A/B (unsigned)
//   gnt0_o     out  1      one-cycle grant to requester 0 (operands taken at next edge)
//   gnt1_o     out  1      one-cycle grant to requester 1 (operands taken at next edge)
//   busy_o     out  1      high whenever the FSM is not idle
//   done_o     out  1      one-cycle result-valid pulse
//   done_id_o  out  1      requester served by the current/last result
//   diff_o     out  WIDTH  |A-B|
//   neg_o      out  1      high when A<B
// ----------------------------------------------------------------------------
module abs_diff_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_b_i,
  input  logic             req0_i,
  input  logic [WIDTH-1:0] a0_i,
  input  logic [WIDTH-1:0] b0_i,
  input  logic             req1_i,
  input  logic [WIDTH-1:0] a1_i,
  input  logic [WIDTH-1:0] b1_i,
  output logic             gnt0_o,
  output logic             gnt1_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             done_id_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             neg_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_CONV = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  // Captured operands and the working result register
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_id;
  logic             r_last_id;

  // Registered result outputs; they change only when a result completes
  logic [WIDTH-1:0] r_diff;
  logic             r_neg;
  logic             r_done_id;

  logic             w_gnt0;
  logic             w_gnt1;
  logic [WIDTH:0]   w_sub;
  logic             w_borrow;
  logic [WIDTH-1:0] w_res_neg;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;

  // Two's-complement negate at WIDTH bits. Applied only after a borrow, so
  // the input is never zero and the result is the true magnitude B-A.
  function automatic logic [WIDTH-1:0] f_negate(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Arbitration: a lone request wins outright. On a tie, the requester that
  // was not served last wins. Grants exist only while idle.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == S_IDLE) begin
      if (req0_i && req1_i) begin
        w_gnt0 = r_last_id;
        w_gnt1 = ~r_last_id;
      end else begin
        w_gnt0 = req0_i;
        w_gnt1 = req1_i;
      end
    end
  end

  assign w_op_a = w_gnt1 ? a1_i : a0_i;
  assign w_op_b = w_gnt1 ? b1_i : b0_i;

  // Zero-extended subtraction. The extra MSB is the borrow (A<B).
  assign w_sub     = {1'b0, r_a} - {1'b0, r_b};
  assign w_borrow  = w_sub[WIDTH];
  assign w_res_neg = f_negate(r_res);

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_gnt0 || w_gnt1) begin
          w_state_nxt = S_SUB;
        end
      end
      S_SUB: begin
        w_state_nxt = w_borrow ? S_CONV : S_DONE;
      end
      S_CONV: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register. last_id resets to 1 so that requester 0 wins the first tie.
  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      r_state   <= S_IDLE;
      r_last_id <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt0 || w_gnt1) begin
        r_last_id <= w_gnt1;
      end
    end
  end

  // Datapath registers. Output registers are loaded on the edge that enters
  // S_DONE, so they present the result during done_o and then hold it while
  // the next operation reuses the working register.
  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_id      <= 1'b0;
      r_diff    <= '0;
      r_neg     <= 1'b0;
      r_done_id <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_a  <= w_op_a;
            r_b  <= w_op_b;
            r_id <= w_gnt1;
          end
        end
        S_SUB: begin
          r_res <= w_sub[WIDTH-1:0];
          if (!w_borrow) begin
            r_diff    <= w_sub[WIDTH-1:0];
            r_neg     <= 1'b0;
            r_done_id <= r_id;
          end
        end
        S_CONV: begin
          r_res     <= w_res_neg;
          r_diff    <= w_res_neg;
          r_neg     <= 1'b1;
          r_done_id <= r_id;
        end
        default: begin
        end
      endcase
    end
  end

  assign gnt0_o    = w_gnt0;
  assign gnt1_o    = w_gnt1;
  assign busy_o    = (r_state != S_IDLE);
  assign done_o    = (r_state == S_DONE);
  assign diff_o    = r_diff;
  assign neg_o     = r_neg;
  assign done_id_o = r_done_id;

endmodule

// File: tb/tb_abs_diff_sched.sv
// ----------------------------------------------------------------------------
// tb_abs_diff_sched
//   Scoreboard bench for abs_diff_sched. The stimulus process drives the
//   requests. The monitor process does the following:
//     - predicts every grant from a round-robin model,
//     - queues the expected |A-B| result for each grant,
//     - compares each done_o against the head of the queue, including latency.
// ----------------------------------------------------------------------------
module tb_abs_diff_sched;
  localparam int W = 8;

  logic         clk_i   = 1'b0;
  logic         rst_b_i = 1'b0;
  logic         req0_i  = 1'b0;
  logic [W-1:0] a0_i    = '0;
  logic [W-1:0] b0_i    = '0;
  logic         req1_i  = 1'b0;
  logic [W-1:0] a1_i    = '0;
  logic [W-1:0] b1_i    = '0;
  logic         gnt0_o;
  logic         gnt1_o;
  logic         busy_o;
  logic         done_o;
  logic         done_id_o;
  logic [W-1:0] diff_o;
  logic         neg_o;

  abs_diff_sched #(.WIDTH(W)) dut (
    .clk_i     (clk_i),
    .rst_b_i   (rst_b_i),
    .req0_i    (req0_i),
    .a0_i      (a0_i),
    .b0_i      (b0_i),
    .req1_i    (req1_i),
    .a1_i      (a1_i),
    .b1_i      (b1_i),
    .gnt0_o    (gnt0_o),
    .gnt1_o    (gnt1_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .done_id_o (done_id_o),
    .diff_o    (diff_o),
    .neg_o     (neg_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int id;
    int diff;
    int neg;
    int gcyc;
    int lat;
  } exp_t;

  exp_t q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   stim_to   = 0;
  bit   stim_done = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom_range(0, (1 << W) - 1));
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    int   cyc = 0;
    int   tb_last = 1;
    int   last_diff = 0;
    int   last_neg = 0;
    int   last_id = 0;
    bit   exp_busy;
    logic [1:0] exp_g;
    exp_t e;
    forever begin
      @(negedge clk_i or negedge rst_b_i);
      if (stim_done) break;
      if (cyc > 20000) begin
        chk("watchdog", cyc, 20000);
        break;
      end
      if (!rst_b_i) begin
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_gnt", {gnt1_o, gnt0_o}, 0);
        chk("rst_diff", diff_o, 0);
        chk("rst_neg", neg_o, 0);
        chk("rst_done_id", done_id_o, 0);
        q.delete();
        tb_last   = 1;
        last_diff = 0;
        last_neg  = 0;
        last_id   = 0;
        continue;
      end
      cyc++;
      exp_busy = (q.size() != 0);
      chk("busy", busy_o, exp_busy);
      exp_g = 2'b00;
      if (!exp_busy) begin
        if (req0_i && req1_i) exp_g = (tb_last == 1) ? 2'b01 : 2'b10;
        else                  exp_g = {req1_i, req0_i};
      end
      chk("grant", {gnt1_o, gnt0_o}, exp_g);

      if (done_o) begin
        if (q.size() == 0) begin
          chk("spurious_done", done_o, 0);
        end else begin
          e = q.pop_front();
          chk("latency", cyc - e.gcyc, e.lat);
          chk("diff", diff_o, e.diff);
          chk("neg", neg_o, e.neg);
          chk("done_id", done_id_o, e.id);
          last_diff = e.diff;
          last_neg  = e.neg;
          last_id   = e.id;
        end
      end else if (q.size() != 0 && (cyc - q[0].gcyc) > q[0].lat) begin
        chk("done_timeout", cyc - q[0].gcyc, q[0].lat);
        void'(q.pop_front());
      end
      chk("hold_diff", diff_o, last_diff);
      chk("hold_neg", neg_o, last_neg);
      chk("hold_id", done_id_o, last_id);

      if (exp_g != 2'b00) begin
        int a;
        int b;
        e.id = exp_g[1] ? 1 : 0;
        a    = (e.id == 1) ? int'(a1_i) : int'(a0_i);
        b    = (e.id == 1) ? int'(b1_i) : int'(b0_i);
        e.diff = (a >= b) ? a - b : b - a;
        e.neg  = (a < b) ? 1 : 0;
        e.lat  = (a < b) ? 3 : 2;
        e.gcyc = cyc;
        q.push_back(e);
        tb_last = e.id;
      end
    end
    chk("stim_timeouts", stim_to, 0);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_gnt(input int id);
    bit ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if ((id == 0 && gnt0_o) || (id == 1 && gnt1_o) || (id == 2 && (gnt0_o || gnt1_o))) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) stim_to++;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (!busy_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) stim_to++;
  endtask

  // One isolated request. The operand bus is scrambled right after the grant.
  task automatic single(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    tick();
    if (id == 0) begin req0_i = 1'b1; a0_i = a; b0_i = b; end
    else         begin req1_i = 1'b1; a1_i = a; b1_i = b; end
    wait_gnt(id);
    tick();
    if (id == 0) begin req0_i = 1'b0; a0_i = rnd_op(); b0_i = rnd_op(); end
    else         begin req1_i = 1'b0; a1_i = rnd_op(); b1_i = rnd_op(); end
    wait_idle();
  endtask

  initial begin : stimulus
    bit g0;
    bit g1;
    repeat (2) @(posedge clk_i);
    #1 rst_b_i = 1'b1;

    single(0, 8'd200, 8'd55);
    single(1, 8'd10, 8'd250);
    single(0, 8'd77, 8'd77);
    single(1, 8'd0, 8'd255);
    single(0, 8'd0, 8'd255);
    single(1, 8'd255, 8'd0);

    // Both requests held continuously: grants must alternate.
    tick();
    req0_i = 1'b1; a0_i = rnd_op(); b0_i = rnd_op();
    req1_i = 1'b1; a1_i = rnd_op(); b1_i = rnd_op();
    for (int k = 0; k < 8; k++) begin
      wait_gnt(2);
      g0 = gnt0_o;
      g1 = gnt1_o;
      tick();
      if (g0) begin a0_i = rnd_op(); b0_i = rnd_op(); end
      if (g1) begin a1_i = rnd_op(); b1_i = rnd_op(); end
    end
    req0_i = 1'b0;
    req1_i = 1'b0;
    wait_idle();

    // Abort an operation in S_SUB with reset; requester 0 was served last.
    tick();
    req0_i = 1'b1; a0_i = 8'd3; b0_i = 8'd9;
    wait_gnt(0);
    tick();
    req0_i = 1'b0;
    #2 rst_b_i = 1'b0;
    tick();
    rst_b_i = 1'b1;
    req0_i = 1'b1; a0_i = rnd_op(); b0_i = rnd_op();
    req1_i = 1'b1; a1_i = rnd_op(); b1_i = rnd_op();
    wait_gnt(0);
    tick();
    req0_i = 1'b0;
    wait_gnt(1);
    tick();
    req1_i = 1'b0;
    wait_idle();

    // Random traffic. Requests are held until granted, except for occasional
    // withdrawals, and some requests are raised while the block is busy.
    tick();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_i);
      g0 = gnt0_o;
      g1 = gnt1_o;
      tick();
      if (req0_i) begin
        if (g0) begin
          req0_i = 1'($urandom_range(0, 1));
          a0_i = rnd_op();
          b0_i = rnd_op();
        end else if ($urandom_range(0, 19) == 0) begin
          req0_i = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        req0_i = 1'b1;
        a0_i = rnd_op();
        b0_i = rnd_op();
      end
      if (req1_i) begin
        if (g1) begin
          req1_i = 1'($urandom_range(0, 1));
          a1_i = rnd_op();
          b1_i = rnd_op();
        end else if ($urandom_range(0, 19) == 0) begin
          req1_i = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        req1_i = 1'b1;
        a1_i = rnd_op();
        b1_i = rnd_op();
      end
    end

    // Let any request still pending be served, then drain.
    @(negedge clk_i);
    g0 = gnt0_o;
    g1 = gnt1_o;
    tick();
    if (g0) req0_i = 1'b0;
    if (g1) req1_i = 1'b0;
    while (req0_i || req1_i) begin
      wait_gnt(2);
      g0 = gnt0_o;
      g1 = gnt1_o;
      tick();
      if (g0) req0_i = 1'b0;
      if (g1) req1_i = 1'b0;
      if (!g0 && !g1) begin
        req0_i = 1'b0;
        req1_i = 1'b0;
      end
    end
    wait_idle();
    repeat (2) tick();
    stim_done = 1'b1;
  end

endmodule
